// File: rtl/jzjpcc_mmio_pkg.sv
// Shared definitions for the jzjpcc memory-mapped IO controller.
// Contents:
//   mmio_bank_e       - register bank selected by the upper window offset bits
//   expandByteEnable  - turns a 4-bit byte enable into a 32-bit bit mask
//   mergeBytes        - replaces only the enabled bytes of a word
package jzjpcc_mmio_pkg;

  typedef enum logic [1:0] {
    MMIO_BANK_OUT     = 2'd0,
    MMIO_BANK_DIR     = 2'd1,
    MMIO_BANK_IN      = 2'd2,
    MMIO_BANK_PENDING = 2'd3
  } mmio_bank_e;

  function automatic logic [31:0] expandByteEnable(input logic [3:0] byteEnable);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{byteEnable[i]}};
    end
    return mask;
  endfunction

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0]  byteEnable);
    logic [31:0] mask;
    mask = expandByteEnable(byteEnable);
    return (oldWord & ~mask) | (newWord & mask);
  endfunction

endpackage

// File: rtl/jzjpcc_mmio_input_sync.sv
// Input path for one 32-bit IO port: synchroniser chain, previous-value
// register and sticky change-pending flags.
// Ports:
//   clock, reset  - core clock, synchronous active-high reset
//   raw           - asynchronous external input word
//   clearMask     - write-1-to-clear mask for the pending flags
//   detectEnable  - change detection allowed (synchroniser warm-up done)
//   synced        - output of the last synchroniser stage
//   pending       - sticky change flags
module jzjpcc_mmio_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] raw,
  input  logic [31:0] clearMask,
  input  logic        detectEnable,
  output logic [31:0] synced,
  output logic [31:0] pending
);

  logic [31:0] chain [SYNC_STAGES];
  logic [31:0] prev;

  assign synced = chain[SYNC_STAGES-1];

  // A fresh change is ORed in after the clear, so a simultaneous set wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        chain[i] <= '0;
      end
      prev    <= '0;
      pending <= '0;
    end else begin
      chain[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      prev    <= synced;
      pending <= (pending & ~clearMask) | (detectEnable ? (synced ^ prev) : 32'h0);
    end
  end

endmodule

// File: rtl/jzjpcc_mmio_controller.sv
// Memory-mapped IO block for the jzjpcc core. The window holds four banks
// (OUT, DIR, IN, PENDING) of NUM_PORTS words each.
// Ports:
//   clock, reset     - core clock, synchronous active-high reset
//   busAddress       - byte address from the memory stage ([1:0] ignored)
//   busWriteData     - write data
//   busByteEnable    - per-byte write enables
//   busWriteEnable   - write strobe
//   busReadEnable    - read strobe
//   busHit           - combinational: address falls inside the window
//   busReadData      - registered read data, 0 when no hit read last cycle
//   mmioInputs       - raw external inputs, one word per port
//   mmioOutputs      - output data registers
//   mmioDirection    - per-bit direction registers (1 = drive)
//   irq              - registered OR of all pending flags
module jzjpcc_mmio_controller
  import jzjpcc_mmio_pkg::*;
#(
  parameter int          NUM_PORTS   = 8,
  parameter logic [31:0] BASE_ADDR   = 32'hFFFFFF80,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [31:0]                busAddress,
  input  logic [31:0]                busWriteData,
  input  logic [3:0]                 busByteEnable,
  input  logic                       busWriteEnable,
  input  logic                       busReadEnable,
  output logic                       busHit,
  output logic [31:0]                busReadData,
  input  logic [NUM_PORTS-1:0][31:0] mmioInputs,
  output logic [NUM_PORTS-1:0][31:0] mmioOutputs,
  output logic [NUM_PORTS-1:0][31:0] mmioDirection,
  output logic                       irq
);

  localparam int         PORT_SHIFT = $clog2(NUM_PORTS);
  localparam int         WIN_BITS   = PORT_SHIFT + 4;
  localparam int         PORT_BITS  = (PORT_SHIFT == 0) ? 1 : PORT_SHIFT;
  localparam logic [3:0] WARM_MAX   = 4'(SYNC_STAGES + 1);

  logic [31:0]                offset;
  logic [PORT_BITS-1:0]       portSel;
  mmio_bank_e                 bankSel;
  logic                       writeHit;
  logic                       readHit;
  logic [31:0]                readMux;
  logic [3:0]                 warmCount;
  logic                       detectEnable;
  logic [NUM_PORTS-1:0][31:0] syncedIn;
  logic [NUM_PORTS-1:0][31:0] pendingBits;
  logic [NUM_PORTS-1:0][31:0] clearMasks;

  // The base is aligned to the window size, so comparing the bits above the
  // window is an exact range test and cannot overflow at the top of memory.
  assign busHit   = (busAddress >> WIN_BITS) == (BASE_ADDR >> WIN_BITS);
  assign offset   = busAddress - BASE_ADDR;
  assign portSel  = PORT_BITS'((offset >> 2) & 32'(NUM_PORTS - 1));
  assign bankSel  = mmio_bank_e'(2'((offset >> (PORT_SHIFT + 2)) & 32'd3));
  assign writeHit = busWriteEnable & busHit;
  assign readHit  = busReadEnable & busHit;

  // Detection stays off until the chain and prev have refilled after reset.
  assign detectEnable = (warmCount == WARM_MAX);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : gen_port
    jzjpcc_mmio_input_sync #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_input_sync (
      .clock        (clock),
      .reset        (reset),
      .raw          (mmioInputs[p]),
      .clearMask    (clearMasks[p]),
      .detectEnable (detectEnable),
      .synced       (syncedIn[p]),
      .pending      (pendingBits[p])
    );
  end

  // W1C mask: only the addressed port, only within enabled bytes.
  always_comb begin
    clearMasks = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (writeHit && (bankSel == MMIO_BANK_PENDING) && (portSel == PORT_BITS'(p))) begin
        clearMasks[p] = busWriteData & expandByteEnable(busByteEnable);
      end
    end
  end

  always_comb begin
    readMux = '0;
    case (bankSel)
      MMIO_BANK_OUT:     readMux = mmioOutputs[portSel];
      MMIO_BANK_DIR:     readMux = mmioDirection[portSel];
      MMIO_BANK_IN:      readMux = syncedIn[portSel];
      MMIO_BANK_PENDING: readMux = pendingBits[portSel];
      default:           readMux = '0;
    endcase
  end

  // readMux samples pre-edge state, so a same-cycle write is not visible.
  always_ff @(posedge clock) begin
    if (reset) begin
      mmioOutputs   <= '0;
      mmioDirection <= '0;
      busReadData   <= '0;
      irq           <= 1'b0;
      warmCount     <= '0;
    end else begin
      if (writeHit && (bankSel == MMIO_BANK_OUT)) begin
        mmioOutputs[portSel] <= mergeBytes(mmioOutputs[portSel], busWriteData, busByteEnable);
      end
      if (writeHit && (bankSel == MMIO_BANK_DIR)) begin
        mmioDirection[portSel] <= mergeBytes(mmioDirection[portSel], busWriteData, busByteEnable);
      end
      busReadData <= readHit ? readMux : 32'h0;
      irq         <= |pendingBits;
      if (warmCount != WARM_MAX) begin
        warmCount <= warmCount + 4'd1;
      end
    end
  end

endmodule

// File: doc/jzjpcc_mmio_controller.md
Name: jzjpcc_mmio_controller

Overview:
Parametrised memory-mapped IO block for the jzjpcc core, generalising the core's fixed 8-in/8-out word ports. Port count and address window are configurable. Adds per-byte write enables, a direction register per port, input synchronisers, change detection with write-1-to-clear pending flags, and an interrupt request output. Sits beside the memory backend; the memory stage drives the bus side, and external logic connects to the port side.

Parameters:
NUM_PORTS, 8, number of 32-bit IO ports; power of two, 1..16
BASE_ADDR, 32'hFFFFFF80, byte address of the window start; aligned to 16*NUM_PORTS bytes
SYNC_STAGES, 2, input synchroniser depth; 2..4

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high
busAddress  in  32  byte address from the memory stage
busWriteData  in  32  write data
busByteEnable  in  4  per-byte write enables; bit n covers byte [8n+7:8n]
busWriteEnable  in  1  write strobe
busReadEnable  in  1  read strobe
busHit  out  1  combinational: busAddress lies inside the window
busReadData  out  32  registered read data
mmioInputs  in  32 x NUM_PORTS  raw external inputs; may be asynchronous
mmioOutputs  out  32 x NUM_PORTS  output data registers
mmioDirection  out  32 x NUM_PORTS  per-bit direction; 1 = drive
irq  out  1  registered; high while any pending bit is set

Behaviour:
- Window size is 16*NUM_PORTS bytes. Offset = busAddress - BASE_ADDR.
  - bank = offset[log2(NUM_PORTS)+3 : log2(NUM_PORTS)+2]
  - port = offset[log2(NUM_PORTS)+1 : 2]
  - busAddress[1:0] is ignored.
- Banks:
  - 0 OUT: read/write
  - 1 DIR: read/write
  - 2 IN: read-only; writes are ignored
  - 3 PENDING: read; write-1-to-clear
- Writes to OUT/DIR take effect at the clock edge, only on bytes whose busByteEnable bit is set; other bytes are unchanged. A PENDING clear applies only within enabled bytes.
- Writes and reads with busHit=0 have no effect. If busHit=0 during a read, busReadData is 0 on the next cycle.
- Read latency is 1 cycle. busReadData at edge N+1 reflects register state before any write at edge N. A same-cycle read and write to the same register returns the old value.
- When no hit read occurred in the previous cycle, busReadData = 0.
- Input path: each port passes through a SYNC_STAGES flop chain to give synced[p]. One further register holds prev[p].
- Change detection: pending[p] |= synced[p] ^ prev[p].
- Simultaneous new change and W1C on the same bit: set wins, so the bit stays 1.
- Warm-up counter after reset:
  - Counts 0..SYNC_STAGES+1, then saturates.
  - Change detection is suppressed until it saturates. No spurious pending is set by synchroniser fill.
  - IN bank reads during warm-up return the chain contents, which are 0 after reset.
- irq is registered: irq(N+1) = OR of all pending bits after the update at edge N.
- Reset (synchronous, any state, including mid-read):
  - mmioOutputs, mmioDirection, pending, sync chains, prev, busReadData, irq all go to 0.
  - Warm-up counter goes to 0.
  - A read issued in the reset cycle returns 0.
- Unused bank/port encodings do not exist, since the window is exactly sized.

Decomposition:
- Package jzjpcc_mmio_pkg holds:
  - bank enum: MMIO_BANK_OUT=2'd0, MMIO_BANK_DIR=2'd1, MMIO_BANK_IN=2'd2, MMIO_BANK_PENDING=2'd3
  - function for byte-enable merge: (old, new, be) -> word
- Sub-module jzjpcc_mmio_input_sync, instantiated once per port:
  - Sync chain, prev register and pending register.
  - Inputs: raw, clearMask, detectEnable.
  - Outputs: synced, pending.

Test Plan:
- Reset, then write 32'hDEADBEEF with busByteEnable=4'b0101 to BASE+0x04 (OUT port 1) -> mmioOutputs[1]=32'h00AD00EF; next-cycle read of BASE+0x04 returns 32'h00AD00EF.
- Write 32'hFFFF0000 to BASE+0x20 (DIR port 0) with be=4'hF, and issue a same-cycle read of BASE+0x20 -> read returns 0; a second read returns 32'hFFFF0000; mmioDirection[0]=32'hFFFF0000.
- Hold mmioInputs[3]=32'h5 from reset -> pending stays 0 and irq=0 through warm-up. Change mmioInputs[3] to 32'h7 -> after SYNC_STAGES+1 cycles, PENDING port 3 (BASE+0x6C) reads 32'h2 and irq=1 one cycle later.
- Write 32'h2 to BASE+0x6C while mmioInputs[3] toggles bit 1 again in the same detect cycle -> pending stays 32'h2 (set wins). Write 32'h2 again with no input change -> pending=0, irq falls next cycle.
- Write 32'h1234 to BASE+0x40 (IN port 0) -> no state change. Access 32'h00000100 -> busHit=0 and next busReadData=0.
- Assert reset for 1 cycle mid-read with OUT port 2 = 32'hA5A5A5A5 -> all outputs are 0 on the following cycle and irq=0.
